// File: rtl/mips_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : mips_control_fsm
//  Brief    : Multicycle MIPS main controller (Moore FSM) with ALU decoder
//             and retired-instruction counter.
//  Revision : 1.0  initial release
// ============================================================================
module mips_control_fsm #(
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [5:0]             op,
    input  logic [5:0]             funct,
    input  logic                   zero,
    output logic                   i_or_d,
    output logic                   ir_write,
    output logic                   mem_write,
    output logic                   reg_write,
    output logic                   reg_dst,
    output logic                   mem_to_reg,
    output logic                   alu_src_a,
    output logic [1:0]             alu_src_b,
    output logic [1:0]             pc_src,
    output logic                   pc_en,
    output logic [2:0]             alu_control,
    output logic [3:0]             state,
    output logic [COUNT_WIDTH-1:0] instr_count
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
    } state_t;

    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_J     = 6'b000010;

    localparam logic [1:0] c_ALUOP_ADD   = 2'b00;
    localparam logic [1:0] c_ALUOP_SUB   = 2'b01;
    localparam logic [1:0] c_ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] c_ALU_AND = 3'b000;
    localparam logic [2:0] c_ALU_OR  = 3'b001;
    localparam logic [2:0] c_ALU_ADD = 3'b010;
    localparam logic [2:0] c_ALU_SUB = 3'b110;
    localparam logic [2:0] c_ALU_SLT = 3'b111;

    state_t                   r_state_q;
    state_t                   w_state_d;
    logic [COUNT_WIDTH-1:0]   r_count_q;
    logic                     w_pc_write;
    logic                     w_branch;
    logic [1:0]               w_alu_op;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q <= S_FETCH;
            r_count_q <= '0;
        end else begin
            r_state_q <= w_state_d;
            if (r_state_q == S_FETCH) begin
                r_count_q <= r_count_q + COUNT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        w_state_d = S_FETCH;
        case (r_state_q)
            S_FETCH: w_state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    c_OP_LW, c_OP_SW: w_state_d = S_MEMADR;
                    c_OP_RTYPE:       w_state_d = S_RTYPEEX;
                    c_OP_BEQ:         w_state_d = S_BEQEX;
                    c_OP_ADDI:        w_state_d = S_ADDIEX;
                    c_OP_J:           w_state_d = S_JEX;
                    default:          w_state_d = S_FETCH;
                endcase
            end
            S_MEMADR:  w_state_d = (op == c_OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   w_state_d = S_MEMWB;
            S_RTYPEEX: w_state_d = S_RTYPEWB;
            S_ADDIEX:  w_state_d = S_ADDIWB;
            // Terminal states and illegal encodings all return to fetch.
            default:   w_state_d = S_FETCH;
        endcase
    end

    always_comb begin
        i_or_d     = 1'b0;
        ir_write   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_src     = 2'b00;
        w_pc_write = 1'b0;
        w_branch   = 1'b0;
        w_alu_op   = c_ALUOP_ADD;
        case (r_state_q)
            S_FETCH: begin
                ir_write   = 1'b1;
                w_pc_write = 1'b1;
                alu_src_b  = 2'b01;
            end
            S_DECODE: alu_src_b = 2'b11;
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: i_or_d = 1'b1;
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                i_or_d    = 1'b1;
                mem_write = 1'b1;
            end
            S_RTYPEEX: begin
                alu_src_a = 1'b1;
                w_alu_op  = c_ALUOP_FUNCT;
            end
            S_RTYPEWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BEQEX: begin
                alu_src_a = 1'b1;
                w_alu_op  = c_ALUOP_SUB;
                pc_src    = 2'b01;
                w_branch  = 1'b1;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_ADDIWB: reg_write = 1'b1;
            S_JEX: begin
                pc_src     = 2'b10;
                w_pc_write = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        alu_control = c_ALU_ADD;
        case (w_alu_op)
            c_ALUOP_SUB: alu_control = c_ALU_SUB;
            c_ALUOP_FUNCT: begin
                case (funct)
                    6'b100000: alu_control = c_ALU_ADD;
                    6'b100010: alu_control = c_ALU_SUB;
                    6'b100100: alu_control = c_ALU_AND;
                    6'b100101: alu_control = c_ALU_OR;
                    6'b101010: alu_control = c_ALU_SLT;
                    default:   alu_control = c_ALU_ADD;
                endcase
            end
            default: alu_control = c_ALU_ADD;
        endcase
    end

    assign pc_en       = w_pc_write | (w_branch & zero);
    assign state       = r_state_q;
    assign instr_count = r_count_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mips_control_fsm
//  Brief    : Scoreboard bench; a per-instruction reference model predicts
//             every cycle's outputs, a negedge monitor compares them.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mips_control_fsm;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [5:0]    op;
    logic [5:0]    funct;
    logic          zero;
    logic          i_or_d, ir_write, mem_write, reg_write, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0]    alu_src_b, pc_src;
    logic          pc_en;
    logic [2:0]    alu_control;
    logic [3:0]    state;
    logic [CW-1:0] instr_count;

    mips_control_fsm #(.COUNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .i_or_d(i_or_d), .ir_write(ir_write), .mem_write(mem_write),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src),
        .pc_en(pc_en), .alu_control(alu_control), .state(state),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]    st;
        logic          i_or_d, ir_write, mem_write, reg_write, reg_dst, mem_to_reg, alu_src_a;
        logic [1:0]    alu_src_b, pc_src;
        logic          pc_en;
        logic [2:0]    alu_control;
        logic [CW-1:0] cnt;
    } rec_t;

    rec_t       sb[$];
    int         checks = 0;
    int         passed = 0;
    int         cycle  = 0;
    logic [CW-1:0] r_exp_cnt;

    // Instruction class -> sequence of state codes it walks through.
    function automatic void seq_of(input logic [5:0] o, output int s[$]);
        s = {0, 1};
        case (o)
            6'b100011: s = {0, 1, 2, 3, 4};
            6'b101011: s = {0, 1, 2, 5};
            6'b000000: s = {0, 1, 6, 7};
            6'b000100: s = {0, 1, 8};
            6'b001000: s = {0, 1, 9, 10};
            6'b000010: s = {0, 1, 11};
            default:   s = {0, 1};
        endcase
    endfunction

    function automatic logic [2:0] funct_alu(input logic [5:0] f);
        case (f)
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    function automatic rec_t expect_of(input int s, input logic [5:0] f, input logic z,
                                       input logic [CW-1:0] c);
        rec_t r;
        r             = '0;
        r.st          = 4'(s);
        r.cnt         = c;
        r.alu_control = 3'b010;
        case (s)
            0:  begin r.ir_write = 1'b1; r.pc_en = 1'b1; r.alu_src_b = 2'b01; end
            1:  r.alu_src_b = 2'b11;
            2:  begin r.alu_src_a = 1'b1; r.alu_src_b = 2'b10; end
            3:  r.i_or_d = 1'b1;
            4:  begin r.reg_write = 1'b1; r.mem_to_reg = 1'b1; end
            5:  begin r.i_or_d = 1'b1; r.mem_write = 1'b1; end
            6:  begin r.alu_src_a = 1'b1; r.alu_control = funct_alu(f); end
            7:  begin r.reg_write = 1'b1; r.reg_dst = 1'b1; end
            8:  begin r.alu_src_a = 1'b1; r.alu_control = 3'b110; r.pc_src = 2'b01; r.pc_en = z; end
            9:  begin r.alu_src_a = 1'b1; r.alu_src_b = 2'b10; end
            10: r.reg_write = 1'b1;
            11: begin r.pc_src = 2'b10; r.pc_en = 1'b1; end
            default: ;
        endcase
        return r;
    endfunction

    // Entered just after a rising edge; drives one instruction cycle by cycle.
    // zmode: 0/1 force zero, 2 randomises it. rst_at: cycle index that asserts reset.
    task automatic issue(input logic [5:0] o, input logic [5:0] f, input int zmode,
                         input int rst_at);
        int s[$];
        seq_of(o, s);
        for (int k = 0; k < s.size(); k++) begin
            op    = o;
            funct = f;
            zero  = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
            reset = (k == rst_at);
            sb.push_back(expect_of(s[k], f, zero, r_exp_cnt));
            if (reset) r_exp_cnt = '0;
            else if (s[k] == 0) r_exp_cnt = r_exp_cnt + 1'b1;
            @(posedge clk);
            #1;
            if (k == rst_at) break;
        end
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        rec_t act, e;
        cycle <= cycle + 1;
        if (sb.size() > 0) begin
            e   = sb.pop_front();
            act = '{state, i_or_d, ir_write, mem_write, reg_write, reg_dst, mem_to_reg,
                    alu_src_a, alu_src_b, pc_src, pc_en, alu_control, instr_count};
            checks = checks + 1;
            if (act === e) passed = passed + 1;
            else $display("FAIL cycle %0d state%0d outputs: got %h want %h", cycle, e.st, act, e);
        end
    end

    logic [5:0] c_functs [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    logic [5:0] c_ops    [7] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                                 6'b001000, 6'b000010, 6'b111111};

    initial begin
        logic [5:0] ro, rf;
        reset = 1'b1; op = '0; funct = '0; zero = 1'b0;
        r_exp_cnt = '0;
        repeat (3) @(posedge clk);
        #1;
        issue(6'b100011, 6'b000000, 2, -1);
        issue(6'b101011, 6'b000000, 2, -1);
        for (int i = 0; i < 5; i++) issue(6'b000000, c_functs[i], 2, -1);
        issue(6'b000000, 6'b111000, 2, -1);
        issue(6'b000100, 6'b000000, 1, -1);
        issue(6'b000100, 6'b000000, 0, -1);
        issue(6'b000010, 6'b000000, 2, -1);
        issue(6'b111111, 6'b000000, 2, -1);
        issue(6'b001000, 6'b000000, 2, -1);
        // Reset asserted while in RTYPEEX.
        issue(6'b000000, 6'b100010, 2, 2);
        issue(6'b000000, 6'b100101, 2, -1);
        for (int i = 0; i < 150; i++) begin
            ro = ($urandom_range(0, 3) == 0) ? 6'($urandom) : c_ops[$urandom_range(0, 6)];
            rf = ($urandom_range(0, 3) == 0) ? 6'($urandom) : c_functs[$urandom_range(0, 4)];
            issue(ro, rf, 2, ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 4)) : -1);
        end
        for (int t = 0; t < 10 && sb.size() > 0; t++) @(posedge clk);
        @(negedge clk);
        #1;
        checks = checks + 1;
        if (sb.size() == 0) passed = passed + 1;
        else $display("FAIL scoreboard drain: got %0d pending want 0", sb.size());
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mips_control_fsm.md
Name: mips_control_fsm

Overview:
- Multicycle main controller that sits directly upstream of the datapath primitives (ALU, Memory, RegisterFile, MUX2/MUX4, FlipFlopEn).
- Moore FSM sequences each instruction through fetch, decode, execute, memory and writeback, and drives every datapath select and enable.
- Includes the ALU decoder (op/funct to alu_control) and a retired-instruction counter for verification visibility.

Parameters:
- COUNT_WIDTH, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- op  input  6  instruction[31:26] from the instruction register.
- funct  input  6  instruction[5:0] from the instruction register.
- zero  input  1  ALU zero flag.
- i_or_d  output  1  memory address select: 0 = PC, 1 = ALUOut.
- ir_write  output  1  instruction register enable.
- mem_write  output  1  memory write enable.
- reg_write  output  1  register file write enable.
- reg_dst  output  1  destination register select: 0 = rt, 1 = rd.
- mem_to_reg  output  1  writeback data select: 0 = ALUOut, 1 = Data.
- alu_src_a  output  1  ALU operand A select: 0 = PC, 1 = A register.
- alu_src_b  output  2  ALU operand B select: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2.
- pc_src  output  2  next-PC select: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- pc_en  output  1  PC register enable.
- alu_control  output  3  ALU function: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
- state  output  4  current state encoding (debug).
- instr_count  output  COUNT_WIDTH  number of instructions fetched.

Behaviour:
- State register: update on posedge clk. reset = 1 forces FETCH on the next edge and clears instr_count to 0, regardless of current state, including mid-instruction.
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPEEX 6, RTYPEWB 7, BEQEX 8, ADDIEX 9, ADDIWB 10, JEX 11. Codes 12–15 are illegal and go to FETCH.
- Transitions:
  - FETCH -> DECODE.
  - DECODE by op: 100011 lw / 101011 sw -> MEMADR; 000000 -> RTYPEEX; 000100 -> BEQEX; 001000 -> ADDIEX; 000010 -> JEX; any other op -> FETCH (executes as a nop, no state written).
  - MEMADR -> MEMRD if op = lw, else MEMWR.
  - MEMRD -> MEMWB; RTYPEEX -> RTYPEWB; ADDIEX -> ADDIWB.
  - MEMWB, MEMWR, RTYPEWB, BEQEX, ADDIWB, JEX -> FETCH.
- Cycles per instruction: lw 5; sw, R-type, addi 4; beq, j 3; unknown op 2.
- Outputs are combinational from state. Every output not listed below is 0; alu_op defaults to add.
  - FETCH: ir_write = 1, pc_write = 1, alu_src_b = 01, add.
  - DECODE: alu_src_b = 11, add.
  - MEMADR: alu_src_a = 1, alu_src_b = 10, add.
  - MEMRD: i_or_d = 1.
  - MEMWB: reg_write = 1, mem_to_reg = 1.
  - MEMWR: i_or_d = 1, mem_write = 1.
  - RTYPEEX: alu_src_a = 1, alu_src_b = 00, alu_op = funct.
  - RTYPEWB: reg_write = 1, reg_dst = 1.
  - BEQEX: alu_src_a = 1, sub, pc_src = 01, branch = 1.
  - ADDIEX: alu_src_a = 1, alu_src_b = 10, add.
  - ADDIWB: reg_write = 1.
  - JEX: pc_src = 10, pc_write = 1.
- pc_en = pc_write | (branch & zero), combinational. zero matters only in BEQEX.
- ALU decoder: add -> 010; sub -> 110. For funct, decode as follows: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111; unknown funct -> 010.
- instr_count increments by 1 on each clock edge leaving FETCH while reset = 0. It wraps modulo 2^COUNT_WIDTH.
- During the reset cycle, outputs reflect the current state. After reset, outputs are the FETCH values.

Test Plan:
- Reset from RTYPEEX mid-instruction -> next cycle state = 0, ir_write = 1, pc_en = 1, alu_src_b = 01, alu_control = 010, instr_count = 0.
- lw (op 100011) -> state sequence 0,1,2,3,4,0; MEMRD i_or_d = 1; MEMWB reg_write = 1, mem_to_reg = 1, reg_dst = 0; instr_count + 1.
- sw (op 101011) -> state sequence 0,1,2,5,0; mem_write = 1 only in state 5; reg_write never asserted.
- R-type sweep of funct 100000/100010/100100/100101/101010 -> alu_control in RTYPEEX = 010/110/000/001/111; RTYPEWB reg_dst = 1, reg_write = 1.
- beq (op 000100) with zero = 1 -> pc_en = 1, pc_src = 01, alu_control = 110; with zero = 0 -> pc_en = 0; both return to FETCH after 3 cycles.
- j (op 000010) -> JEX pc_src = 10, pc_en = 1. Undefined op 111111 -> DECODE -> FETCH with no write enables asserted. With COUNT_WIDTH = 4, 16 fetches -> instr_count wraps to 0.
